el_fa_ser_drv: RTL and testbench
================================

# el_fa_ser_drv

Clocked bit-serial driver and collector for the LEDR dual-rail full adder stage. It accepts a synchronous operand word, injects one LEDR token per bit (LSB first) on the adder's three input links, and collects the sum and carry tokens. Each carry-out is fed back as the next bit's carry-in. It sits between the synchronous datapath and the asynchronous `el_fa_fl` cell and returns the assembled result word with valid/ready.

## Interface
- `WIDTH`, 8, operand/result width in bits (≥1)
- `SYNC_STAGES`, 2, flop depth of the async-input synchronizers (≥2)
- `TIMEOUT`, 255, maximum cycles spent waiting in any single wait state before abort (≥16)

- `clk` in 1: sole clock
- `rst_n` in 1: reset, asynchronous, active-low
- `op_valid` / `op_ready` in / out 1: operand handshake
- `op_a`, `op_b` in WIDTH: operands
- `op_cin` in 1: initial carry-in
- `res_valid` / `res_ready` out / in 1: result handshake
- `res_sum` out WIDTH: sum word
- `res_cout` out 1: final carry
- `err_timeout` out 1: one-cycle pulse on abort
- `fa_in_a`, `fa_in_b`, `fa_in_c` out 2: LEDR tokens to adder links A/B/C
- `fa_ack_in` in 1: adder input acknowledge (its common A/B/C ack)
- `fa_out_s`, `fa_out_c` in 2: LEDR sum/carry tokens from adder
- `fa_ack_s`, `fa_ack_c` out 1: acknowledges to adder sum/carry links

## Operation
- LEDR encoding: rail[1] = value, rail[0] = value ^ phase, so phase = rail[1]^rail[0]. Each token changes exactly one rail, so a synchronized sample is always either the old token or the new token.
- Acknowledge is two-phase: a token of phase p is acknowledged when the ack level equals p.
- `fa_ack_in`, `fa_out_s` and `fa_out_c` pass through SYNC_STAGES-flop synchronizers. All decisions use the synchronized copies only.
- Token phase register `ph` resets to 0. Each bit uses `ph_n = ~ph`.
- FSM states:
  - IDLE: `op_ready`=1. On `op_valid`, latch a/b, set carry=`op_cin`, clear bit index i and the timeout counter, go to SEND.
  - SEND: drive the A/B/C tokens from a[i], b[i] and carry with phase `ph_n`, all registered in the same cycle. Go to WAIT_OUT.
  - WAIT_OUT: wait until the synced s phase == `ph_n` and the synced c phase == `ph_n`. Then capture sum[i] from the s value rail, set carry from the c value rail, drive `fa_ack_s`=`fa_ack_c`=`ph_n`, and go to WAIT_IN.
  - WAIT_IN: wait until synced `fa_ack_in` == `ph_n`. Then set `ph`=`ph_n`. If i==WIDTH-1, go to DONE; otherwise i++ and go to SEND.
  - DONE: `res_valid`=1, `res_sum`=sum, `res_cout`=carry. On `res_ready`, go to IDLE.
- Timeout counter:
  - Cleared on every state entry; increments in WAIT_OUT and WAIT_IN.
  - On reaching TIMEOUT, pulse `err_timeout` and go to IDLE.
  - The result is discarded and `ph` and the link outputs are left unchanged. A stuck adder requires reset to recover.
- `op_valid` is ignored outside IDLE. `res_sum`/`res_cout` hold their values until the next DONE.

## Timing
- Reset values:
  - `fa_in_*`=2'b00, `fa_ack_s`=`fa_ack_c`=0.
  - `op_ready`=0 for the reset cycle, then 1 in IDLE.
  - `res_valid`=0, `res_sum`=0, `res_cout`=0, `err_timeout`=0.
  - State = IDLE, `ph`=0.
- The first token after reset has phase 1.
- Per-bit minimum latency is 2·SYNC_STAGES+3 cycles: SEND 1, WAIT_OUT ≥SYNC_STAGES+1, WAIT_IN ≥SYNC_STAGES+1, assuming zero adder delay.
- Word minimum latency is WIDTH·(2·SYNC_STAGES+3) cycles from operand accept to `res_valid`.
- Link outputs are registered, glitch-free, and change in exactly one cycle per token. Exactly one rail toggles per link per token.
- The adder's active-high reset must be driven from the same reset event (~`rst_n`). Asserting `rst_n` mid-word returns all links to phase 0 immediately, with no partial result and no `res_valid`.
- Simultaneous `res_ready` and `op_valid` in DONE: the result is consumed and the FSM returns to IDLE. The operand is accepted on the next cycle, never in the same cycle.

## Structure
- Shared package `el_pkg`:
  - FSM state encoding (IDLE, SEND, WAIT_OUT, WAIT_IN, DONE).
  - LEDR encode helper (value, phase → rails).
  - LEDR phase/value extract helpers.
- Sub-module `el_sync`: parameterized multi-bit flop synchronizer, reset to 0, instantiated for `fa_ack_in` (1 bit) and for {`fa_out_s`, `fa_out_c`} (4 bits).

## Test plan
- Bench pairs the block with a behavioural LEDR adder model using random per-transition delays of 0–20 cycles.
- 0x5A + 0x33, cin 0 → `res_sum`=0x8D, `res_cout`=0. Exactly 8 tokens per input link, with `ph`=0 at the end.
- 0xFF + 0x01, cin 0 → 0x00, cout 1. Then 0x00 + 0x00, cin 1 → 0x01, cout 0. Back-to-back, with phases continuing without reset.
- Hold `res_ready`=0 for 50 cycles in DONE → `res_valid` and the result stay stable, `op_ready`=0, and no link activity.
- Model never acks the outputs → `err_timeout` pulses exactly 255 cycles after WAIT_OUT entry, FSM returns to IDLE, and `res_valid` is never asserted.
- Assert `rst_n` low during bit 3 of a word → all outputs return to reset values asynchronously. After release, 0x01 + 0x01 → 0x02 using a first token of phase 1.
- Protocol checker on every link: never more than one rail change per token, and no new token before the previous ack is observed.

Source files
------------

// File: rtl/el_pkg.sv
// Shared types and LEDR helpers for the dual-rail full-adder serial driver.
// rail[1] carries the value; rail[0] is value^phase.
package el_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_OUT,
      ST_WAIT_IN,
      ST_DONE
   } el_state_t;

   function automatic logic [1:0] ledr_enc(input logic i_val, input logic i_ph);
      return {i_val, i_val ^ i_ph};
   endfunction

   function automatic logic ledr_phase(input logic [1:0] i_tok);
      return i_tok[1] ^ i_tok[0];
   endfunction

   function automatic logic ledr_value(input logic [1:0] i_tok);
      return i_tok[1];
   endfunction

endpackage

// File: rtl/el_sync.sv
// Multi-bit flop synchronizer for asynchronous LEDR links, clears to zero on reset.
module el_sync #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else begin
         r_q <= {r_q[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/el_fa_ser_drv.sv
// Bit-serial driver/collector for the LEDR full-adder cell: one token per bit,
// LSB first, carry-out fed back as the next carry-in.
module el_fa_ser_drv
   import el_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             err_timeout,
   output logic [1:0]       fa_in_a,
   output logic [1:0]       fa_in_b,
   output logic [1:0]       fa_in_c,
   input  logic             fa_ack_in,
   input  logic [1:0]       fa_out_s,
   input  logic [1:0]       fa_out_c,
   output logic             fa_ack_s,
   output logic             fa_ack_c
);

   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   el_state_t        r_state, w_next;
   logic             r_ph, w_ph_n;
   logic [WIDTH-1:0] r_a, r_b, r_sum, r_res_sum, w_sum_next;
   logic             r_carry, r_res_cout, r_err, r_started, r_ack_out;
   logic [IW-1:0]    r_idx;
   logic [TW-1:0]    r_tmo;
   logic [1:0]       r_fa_a, r_fa_b, r_fa_c;
   logic             w_ack_in;
   logic [3:0]       w_out_sync;
   logic [1:0]       w_s, w_c;
   logic             w_out_ok, w_in_ok, w_tmo, w_last, w_accept, w_abort;
   logic             w_op_ready;

   el_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ack (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (fa_ack_in),
      .o_q     (w_ack_in)
   );

   el_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_out (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     ({fa_out_s, fa_out_c}),
      .o_q     (w_out_sync)
   );

   assign w_ph_n   = ~r_ph;
   assign w_s      = w_out_sync[3:2];
   assign w_c      = w_out_sync[1:0];
   assign w_out_ok = (ledr_phase(w_s) == w_ph_n) && (ledr_phase(w_c) == w_ph_n);
   assign w_in_ok  = (w_ack_in == w_ph_n);
   assign w_tmo    = (r_tmo == TW'(TIMEOUT - 1));
   assign w_last   = (r_idx == IW'(WIDTH - 1));
   assign w_accept = op_valid && w_op_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_abort = 1'b0;
      case (r_state)
         ST_IDLE:     if (w_accept) w_next = ST_SEND;
         ST_SEND:     w_next = ST_WAIT_OUT;
         ST_WAIT_OUT: begin
            if (w_out_ok) begin
               w_next = ST_WAIT_IN;
            end else if (w_tmo) begin
               w_next  = ST_IDLE;
               w_abort = 1'b1;
            end
         end
         ST_WAIT_IN: begin
            if (w_in_ok) begin
               w_next = w_last ? ST_DONE : ST_SEND;
            end else if (w_tmo) begin
               w_next  = ST_IDLE;
               w_abort = 1'b1;
            end
         end
         ST_DONE:     if (res_ready) w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   // op_ready is held low for the first cycle out of reset via r_started
   always_comb begin
      w_op_ready = (r_state == ST_IDLE) && r_started;
      res_valid  = (r_state == ST_DONE);
   end

   // New sum bit enters at the MSB so the LSB-first word is aligned after WIDTH bits
   always_comb begin
      w_sum_next             = r_sum >> 1;
      w_sum_next[WIDTH-1]    = ledr_value(w_s);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ph       <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_carry    <= 1'b0;
         r_sum      <= '0;
         r_idx      <= '0;
         r_fa_a     <= '0;
         r_fa_b     <= '0;
         r_fa_c     <= '0;
         r_ack_out  <= 1'b0;
         r_res_sum  <= '0;
         r_res_cout <= 1'b0;
         r_err      <= 1'b0;
         r_tmo      <= '0;
         r_started  <= 1'b0;
      end else begin
         r_started <= 1'b1;
         r_err     <= w_abort;
         if (w_next != r_state) begin
            r_tmo <= '0;
         end else if (r_state == ST_WAIT_OUT || r_state == ST_WAIT_IN) begin
            r_tmo <= r_tmo + TW'(1);
         end else begin
            r_tmo <= '0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_carry <= op_cin;
                  r_idx   <= '0;
               end
            end
            ST_SEND: begin
               r_fa_a <= ledr_enc(r_a[0], w_ph_n);
               r_fa_b <= ledr_enc(r_b[0], w_ph_n);
               r_fa_c <= ledr_enc(r_carry, w_ph_n);
            end
            ST_WAIT_OUT: begin
               if (w_out_ok) begin
                  r_sum     <= w_sum_next;
                  r_carry   <= ledr_value(w_c);
                  r_ack_out <= w_ph_n;
               end
            end
            ST_WAIT_IN: begin
               if (w_in_ok) begin
                  r_ph <= w_ph_n;
                  if (w_last) begin
                     r_res_sum  <= r_sum;
                     r_res_cout <= r_carry;
                  end else begin
                     r_idx <= r_idx + IW'(1);
                     r_a   <= r_a >> 1;
                     r_b   <= r_b >> 1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign op_ready    = w_op_ready;
   assign res_sum     = r_res_sum;
   assign res_cout    = r_res_cout;
   assign err_timeout = r_err;
   assign fa_in_a     = r_fa_a;
   assign fa_in_b     = r_fa_b;
   assign fa_in_c     = r_fa_c;
   assign fa_ack_s    = r_ack_out;
   assign fa_ack_c    = r_ack_out;

endmodule

// File: tb/tb_el_fa_ser_drv.sv
// Bench for el_fa_ser_drv: behavioural LEDR full-adder with random delays,
// link protocol monitor, table vectors, random words and corner sequences.
module tb_el_fa_ser_drv;

   localparam int W    = 8;
   localparam int SS   = 2;
   localparam int TMO  = 255;
   localparam int DMAX = 20;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         op_valid = 1'b0, op_cin = 1'b0, res_ready = 1'b0;
   logic [W-1:0] op_a = '0, op_b = '0;
   logic         op_ready, res_valid, res_cout, err_timeout, fa_ack_s, fa_ack_c;
   logic [W-1:0] res_sum;
   logic [1:0]   fa_in_a, fa_in_b, fa_in_c;
   logic [1:0]   m_s, m_c;
   logic         m_ack;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   el_fa_ser_drv #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_cout(res_cout), .err_timeout(err_timeout),
      .fa_in_a(fa_in_a), .fa_in_b(fa_in_b), .fa_in_c(fa_in_c),
      .fa_ack_in(m_ack), .fa_out_s(m_s), .fa_out_c(m_c),
      .fa_ack_s(fa_ack_s), .fa_ack_c(fa_ack_c)
   );

   function automatic logic tphase(input logic [1:0] t);
      return t[1] ^ t[0];
   endfunction

   function automatic logic [1:0] tenc(input logic v, input logic p);
      return {v, v ^ p};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   // Behavioural LEDR full adder; reset is ~rst_n, same event as the driver.
   logic m_ph, m_busy, m_hang = 1'b0, m_sv, m_cv, m_ps, m_pc, m_pa;
   int   m_ds, m_dc, m_da;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s <= 2'b00; m_c <= 2'b00; m_ack <= 1'b0; m_ph <= 1'b0; m_busy <= 1'b0;
         m_ps <= 1'b0; m_pc <= 1'b0; m_pa <= 1'b0; m_sv <= 1'b0; m_cv <= 1'b0;
         m_ds <= 0; m_dc <= 0; m_da <= 0;
      end else if (!m_busy) begin
         if (tphase(fa_in_a) != m_ph && tphase(fa_in_b) != m_ph && tphase(fa_in_c) != m_ph) begin
            {m_cv, m_sv} <= 2'(int'(fa_in_a[1]) + int'(fa_in_b[1]) + int'(fa_in_c[1]));
            m_busy <= 1'b1; m_ps <= 1'b1; m_pc <= 1'b1; m_pa <= 1'b1;
            m_ds <= int'($urandom_range(DMAX, 0));
            m_dc <= int'($urandom_range(DMAX, 0));
            m_da <= int'($urandom_range(DMAX, 0));
         end
      end else begin
         if (m_ps && !m_hang) begin
            if (m_ds == 0) begin m_s <= tenc(m_sv, ~m_ph); m_ps <= 1'b0; end
            else m_ds <= m_ds - 1;
         end
         if (m_pc && !m_hang) begin
            if (m_dc == 0) begin m_c <= tenc(m_cv, ~m_ph); m_pc <= 1'b0; end
            else m_dc <= m_dc - 1;
         end
         if (m_pa) begin
            if (m_da == 0) begin m_ack <= ~m_ph; m_pa <= 1'b0; end
            else m_da <= m_da - 1;
         end
         if (!m_ps && !m_pc && !m_pa && fa_ack_s == ~m_ph && fa_ack_c == ~m_ph) begin
            m_ph <= ~m_ph; m_busy <= 1'b0;
         end
      end
   end

   // Link protocol monitor and token counters
   logic [1:0] p_a = '0, p_b = '0, p_c = '0;
   logic       p_as = 1'b0, p_ac = 1'b0;
   int         tok_a = 0, tok_b = 0, tok_c = 0;

   task automatic link_chk(input string nm, input logic [1:0] prev, input logic [1:0] cur);
      chk({nm, "_one_rail"}, $countones(cur ^ prev), 1);
      chk({nm, "_prev_acked"}, m_ack, tphase(prev));
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         p_a <= '0; p_b <= '0; p_c <= '0; p_as <= 1'b0; p_ac <= 1'b0;
      end else begin
         if (fa_in_a != p_a) begin tok_a++; link_chk("link_a", p_a, fa_in_a); end
         if (fa_in_b != p_b) begin tok_b++; link_chk("link_b", p_b, fa_in_b); end
         if (fa_in_c != p_c) begin tok_c++; link_chk("link_c", p_c, fa_in_c); end
         if (fa_ack_s != p_as) chk("ack_s_matches_token", fa_ack_s, tphase(m_s));
         if (fa_ack_c != p_ac) chk("ack_c_matches_token", fa_ack_c, tphase(m_c));
         p_a <= fa_in_a; p_b <= fa_in_b; p_c <= fa_in_c;
         p_as <= fa_ack_s; p_ac <= fa_ack_c;
      end
   end

   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int n = 0;
      while (!op_ready && n < 200) begin @(negedge clk); n++; end
      chk("op_ready_wait", op_ready, 1);
      op_a = a; op_b = b; op_cin = cin; op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic wait_res(output logic [W-1:0] s, output logic co, output int lat);
      lat = 0;
      while (!res_valid && lat < 3000) begin @(negedge clk); lat++; end
      chk("res_valid_wait", res_valid, 1);
      s = res_sum; co = res_cout;
   endtask

   task automatic take_res();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic run_word(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] es, input logic eco);
      logic [W-1:0] s;
      logic         co;
      int           lat;
      send_op(a, b, cin);
      wait_res(s, co, lat);
      chk({nm, "_sum"}, s, es);
      chk({nm, "_cout"}, co, eco);
      chk({nm, "_min_latency"}, lat >= W * (2 * SS + 3), 1);
      take_res();
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [W-1:0] s0, ra, rb;
      logic         rc, co0, rv_seen, stable;
      logic [8:0]   ref9;
      logic [1:0]   pa, sa, sb, sc;
      int           base_a, base_b, base_c, n, lat;

      tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[1] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      tbl[2] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      tbl[4] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
      tbl[5] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_links", {fa_in_a, fa_in_b, fa_in_c}, 0);
      chk("rst_acks", {fa_ack_s, fa_ack_c}, 0);
      chk("rst_op_ready", op_ready, 0);
      chk("rst_res", {res_valid, res_cout, res_sum}, 0);
      chk("rst_err", err_timeout, 0);
      rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("idle_op_ready", op_ready, 1);

      // First word: token count and final phase
      base_a = tok_a; base_b = tok_b; base_c = tok_c;
      run_word("w5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
      chk("w5a33_tokens_a", tok_a - base_a, 8);
      chk("w5a33_tokens_b", tok_b - base_b, 8);
      chk("w5a33_tokens_c", tok_c - base_c, 8);
      chk("w5a33_end_phase", {tphase(fa_in_a), tphase(fa_in_b), tphase(fa_in_c)}, 0);

      // Back-to-back table vectors, phases continue without reset
      for (int i = 0; i < 6; i++)
         run_word($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co);

      // Random words against plain arithmetic
      for (int i = 0; i < 16; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         ref9 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         run_word($sformatf("rnd%0d", i), ra, rb, rc, ref9[7:0], ref9[8]);
      end

      // Hold in DONE for 50 cycles with a pending operand
      send_op(8'h21, 8'h42, 1'b1);
      wait_res(s0, co0, lat);
      chk("hold_sum", s0, 8'h64);
      sa = fa_in_a; sb = fa_in_b; sc = fa_in_c;
      op_a = 8'h10; op_b = 8'h20; op_cin = 1'b0; op_valid = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!res_valid || res_sum != s0 || res_cout != co0 || op_ready ||
             fa_in_a != sa || fa_in_b != sb || fa_in_c != sc) stable = 1'b0;
      end
      chk("hold_stable", stable, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("done_exit_no_same_cycle_accept", {op_ready, res_valid}, 2'b10);
      @(negedge clk);
      op_valid = 1'b0;
      chk("next_cycle_accept", op_ready, 0);
      wait_res(s0, co0, lat);
      chk("after_hold_sum", {co0, s0}, 9'h030);
      take_res();

      // Reset during bit 3
      base_a = tok_a;
      send_op(8'h77, 8'h11, 1'b0);
      n = 0;
      while (tok_a < base_a + 4 && n < 3000) begin @(negedge clk); n++; end
      chk("midrst_reach_bit3", tok_a >= base_a + 4, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_links", {fa_in_a, fa_in_b, fa_in_c}, 0);
      chk("midrst_acks", {fa_ack_s, fa_ack_c}, 0);
      chk("midrst_res", {op_ready, res_valid, err_timeout, res_cout, res_sum}, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pa = fa_in_a;
      send_op(8'h01, 8'h01, 1'b0);
      n = 0;
      while (fa_in_a == pa && n < 50) begin @(negedge clk); n++; end
      chk("post_rst_first_phase", tphase(fa_in_a), 1);
      wait_res(s0, co0, lat);
      chk("post_rst_result", {co0, s0}, 9'h002);
      take_res();

      // Adder never answers: abort after TIMEOUT cycles in WAIT_OUT
      m_hang = 1'b1;
      pa = fa_in_a;
      send_op(8'h0F, 8'hF0, 1'b0);
      n = 0;
      while (fa_in_a == pa && n < 50) begin @(negedge clk); n++; end
      chk("tmo_token_sent", fa_in_a != pa, 1);
      sa = fa_in_a; sb = fa_in_b; sc = fa_in_c;
      n = 0; rv_seen = 1'b0;
      while (!err_timeout && n < 400) begin
         @(negedge clk); n++;
         if (res_valid) rv_seen = 1'b1;
      end
      chk("tmo_cycles", n, TMO);
      @(negedge clk);
      if (res_valid) rv_seen = 1'b1;
      chk("tmo_pulse_width", err_timeout, 0);
      chk("tmo_back_idle", op_ready, 1);
      chk("tmo_links_held", {fa_in_a, fa_in_b, fa_in_c}, {sa, sb, sc});
      chk("tmo_no_res_valid", rv_seen, 0);
      chk("tmo_result_kept", {res_cout, res_sum}, 9'h002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
